// File: rtl/user_io_ckpt_pkg.sv
// Shared definitions for the checkpoint driver: register map, bit positions,
// PUSH field layout and the replay state encoding.
package user_io_ckpt_pkg;

   // Register offsets (byte address bits [3:0])
   localparam logic [3:0] OFS_CTRL = 4'h0;
   localparam logic [3:0] OFS_PUSH = 4'h4;
   localparam logic [3:0] OFS_STAT = 4'h8;
   localparam logic [3:0] OFS_IDLE = 4'hC;

   // CTRL bits
   localparam int CTRL_EN    = 0;
   localparam int CTRL_OE    = 1;
   localparam int CTRL_FLUSH = 2;

   // STAT bits
   localparam int STAT_LEVEL_LSB = 0;
   localparam int STAT_EMPTY     = 8;
   localparam int STAT_FULL      = 9;
   localparam int STAT_BUSY      = 10;
   localparam int STAT_OVF       = 11;

   // PUSH layout: [WORD_W-1:0] pad word (checkbits + status), hold count above it
   localparam int WORD_W     = 20;
   localparam int PUSH_H_LSB = 20;

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

   // Place a 20-bit pad word onto the 38-bit pad bus (bits [35:16])
   function automatic logic [37:0] pad_word(input logic [WORD_W-1:0] w);
      return {2'b00, w, 16'h0000};
   endfunction

endpackage

// File: rtl/user_io_checkpoint_driver_if.sv
// Wishbone slave bus bundle between firmware (master) and the checkpoint driver.
interface user_io_checkpoint_driver_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/ckpt_fifo.sv
// Synchronous entry queue. Head entry is visible combinationally on dout so the
// replay engine can load it in the same cycle it pops.
module ckpt_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == LW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign level   = count_reg;
   assign dout    = mem[rd_ptr_reg];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointer and occupancy tracking; flush clears the queue in one cycle
   always_ff @(posedge clk) begin
      if (srst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end
endmodule

// File: rtl/user_io_checkpoint_driver.sv
// Checkpoint driver top: Wishbone register file, entry queue and the replay
// engine that holds each queued word on the user pads for H+1 cycles.
module user_io_checkpoint_driver
   import user_io_ckpt_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          FIFO_DEPTH = 16,
   parameter int          HOLD_W     = 12
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   user_io_checkpoint_driver_if.slave   wbs,
   output logic [37:0]                  io_out,
   output logic [37:0]                  io_oeb
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              ack_reg;
   logic [31:0]       dat_o_reg;
   logic              en_reg;
   logic              oe_reg;
   logic              ovf_reg;
   logic [WORD_W-1:0] idle_word_reg;
   state_t            state_reg;
   logic [HOLD_W-1:0] cnt_reg;
   logic [WORD_W-1:0] word_reg;

   logic [3:0]        offset;
   logic              req, wr_req, rd_req;
   logic              flush_req, push_req;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_avail;
   logic [31:0]       fifo_dout;
   logic [LVL_W-1:0]  fifo_level;
   logic              busy;
   logic [31:0]       rdata;

   // Bus decode; a request is ignored while its ack is being returned so ack
   // can never fire on two consecutive cycles
   assign offset    = wbs.wbs_adr_i[3:0];
   assign req       = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_reg &
                      (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign wr_req    = req & wbs.wbs_we_i & (wbs.wbs_sel_i == 4'hF);
   assign rd_req    = req & ~wbs.wbs_we_i;
   assign flush_req = wr_req & (offset == OFS_CTRL) & wbs.wbs_dat_i[CTRL_FLUSH];
   assign push_req  = wr_req & (offset == OFS_PUSH);
   assign fifo_push = push_req & ~fifo_full & ~flush_req;

   // An entry being flushed this cycle is not offered to the replay engine
   assign fifo_avail = ~fifo_empty & ~flush_req;
   assign busy       = (state_reg != IDLE);
   assign fifo_pop   = (state_reg == LOAD) ||
                       ((state_reg == HOLD) && en_reg && (cnt_reg == '0) && fifo_avail);

   ckpt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (wb_clk_i),
      .srst  (wb_rst_i),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (flush_req),
      .din   (wbs.wbs_dat_i),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Read-back mux; PUSH is write-only and unmapped offsets read zero
   always_comb begin
      rdata = '0;
      case (offset)
         OFS_CTRL: begin
            rdata[CTRL_EN] = en_reg;
            rdata[CTRL_OE] = oe_reg;
         end
         OFS_STAT: begin
            rdata[STAT_LEVEL_LSB +: LVL_W] = fifo_level;
            rdata[STAT_EMPTY] = fifo_empty;
            rdata[STAT_FULL]  = fifo_full;
            rdata[STAT_BUSY]  = busy;
            rdata[STAT_OVF]   = ovf_reg;
         end
         OFS_IDLE: rdata[WORD_W-1:0] = idle_word_reg;
         default:  rdata = '0;
      endcase
   end

   // Wishbone slave: ack pulse, registered read data and control registers
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_reg       <= 1'b0;
         dat_o_reg     <= '0;
         en_reg        <= 1'b0;
         oe_reg        <= 1'b0;
         ovf_reg       <= 1'b0;
         idle_word_reg <= '0;
      end else begin
         ack_reg   <= req;
         dat_o_reg <= rd_req ? rdata : '0;
         if (wr_req && (offset == OFS_CTRL)) begin
            en_reg <= wbs.wbs_dat_i[CTRL_EN];
            oe_reg <= wbs.wbs_dat_i[CTRL_OE];
         end
         if (wr_req && (offset == OFS_IDLE))
            idle_word_reg <= wbs.wbs_dat_i[WORD_W-1:0];
         if (wr_req && (offset == OFS_STAT) && wbs.wbs_dat_i[STAT_OVF])
            ovf_reg <= 1'b0;
         if (push_req && fifo_full && !flush_req)
            ovf_reg <= 1'b1;
      end
   end

   // Replay engine: load an entry, hold it H+1 cycles, chain the next without a gap
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         word_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               word_reg <= idle_word_reg;
               if (en_reg && fifo_avail) state_reg <= LOAD;
            end
            LOAD: begin
               word_reg  <= fifo_dout[WORD_W-1:0];
               cnt_reg   <= fifo_dout[PUSH_H_LSB +: HOLD_W];
               state_reg <= HOLD;
            end
            HOLD: begin
               if (!en_reg) begin
                  state_reg <= IDLE;
                  word_reg  <= idle_word_reg;
               end else if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - 1'b1;
               end else if (fifo_avail) begin
                  word_reg <= fifo_dout[WORD_W-1:0];
                  cnt_reg  <= fifo_dout[PUSH_H_LSB +: HOLD_W];
               end else begin
                  state_reg <= IDLE;
                  word_reg  <= idle_word_reg;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign wbs.wbs_ack_o = ack_reg;
   assign wbs.wbs_dat_o = dat_o_reg;
   assign io_out        = pad_word(word_reg);
   assign io_oeb        = {2'b11, {WORD_W{~oe_reg}}, 16'hFFFF};
endmodule

// File: tb/tb_user_io_checkpoint_driver.sv
// Directed bench for the checkpoint driver: register access, replay timing,
// overflow, abort, flush and mid-operation reset.
module tb_user_io_checkpoint_driver;
   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam logic [31:0] A_CTRL = BASE + 32'h0;
   localparam logic [31:0] A_PUSH = BASE + 32'h4;
   localparam logic [31:0] A_STAT = BASE + 32'h8;
   localparam logic [31:0] A_IDLE = BASE + 32'hC;
   localparam logic [19:0] IDLE_W = 20'hF_0F0F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [37:0] io_out;
   logic [37:0] io_oeb;
   int          n_cmp = 0;
   int          n_bad = 0;

   user_io_checkpoint_driver_if wbs_if ();

   user_io_checkpoint_driver #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (16),
      .HOLD_W     (12)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs      (wbs_if.slave),
      .io_out   (io_out),
      .io_oeb   (io_oeb)
   );

   always #5 clk = ~clk;

   function automatic logic [37:0] pad(input logic [19:0] w);
      return {2'b00, w, 16'h0000};
   endfunction

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int   n;
      logic got;
      n = 0;
      @(posedge clk); #1;
      wbs_if.wbs_cyc_i = 1'b1; wbs_if.wbs_stb_i = 1'b1; wbs_if.wbs_we_i = 1'b1;
      wbs_if.wbs_sel_i = s;    wbs_if.wbs_adr_i = a;    wbs_if.wbs_dat_i = d;
      do begin
         @(posedge clk); #1; n++;
      end while (wbs_if.wbs_ack_o !== 1'b1 && n < 8);
      got = wbs_if.wbs_ack_o;
      wbs_if.wbs_cyc_i = 1'b0; wbs_if.wbs_stb_i = 1'b0; wbs_if.wbs_we_i = 1'b0;
      $display("wb write adr=%h dat=%h sel=%h ack=%b", a, d, s, got);
      if (got !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL write_ack adr=%h got=%b required=1", a, got);
      end
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      int n;
      n = 0;
      @(posedge clk); #1;
      wbs_if.wbs_cyc_i = 1'b1; wbs_if.wbs_stb_i = 1'b1; wbs_if.wbs_we_i = 1'b0;
      wbs_if.wbs_sel_i = 4'hF; wbs_if.wbs_adr_i = a;
      do begin
         @(posedge clk); #1; n++;
      end while (wbs_if.wbs_ack_o !== 1'b1 && n < 8);
      d = (wbs_if.wbs_ack_o === 1'b1) ? wbs_if.wbs_dat_o : 32'hDEAD_DEAD;
      if (wbs_if.wbs_ack_o !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL read_ack adr=%h got=%b required=1", a, wbs_if.wbs_ack_o);
      end
      wbs_if.wbs_cyc_i = 1'b0; wbs_if.wbs_stb_i = 1'b0;
      $display("wb read  adr=%h dat=%h", a, d);
   endtask

   task automatic test_reset;
      logic [31:0] d;
      wbs_if.wbs_cyc_i = 1'b0; wbs_if.wbs_stb_i = 1'b0; wbs_if.wbs_we_i = 1'b0;
      wbs_if.wbs_sel_i = 4'h0; wbs_if.wbs_adr_i = '0;   wbs_if.wbs_dat_i = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (io_oeb !== 38'h3F_FFFF_FFFF) begin n_bad++; $display("FAIL reset_oeb got=%h required=%h", io_oeb, 38'h3F_FFFF_FFFF); end
      n_cmp++; if (io_out !== 38'h0) begin n_bad++; $display("FAIL reset_io_out got=%h required=0", io_out); end
      n_cmp++; if (wbs_if.wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b required=0", wbs_if.wbs_ack_o); end
      n_cmp++; if (wbs_if.wbs_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_dat_o got=%h required=0", wbs_if.wbs_dat_o); end
      @(posedge clk); #1; rst = 1'b0;
      wb_read(A_STAT, d);
      n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL reset_stat got=%h required=%h", d, 32'h100); end
      wb_read(A_CTRL, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl got=%h required=0", d); end
      wb_read(A_IDLE, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_idle got=%h required=0", d); end
   endtask

   task automatic test_registers;
      logic [31:0] d;
      int          acks;
      wb_write(A_IDLE, {12'h0, IDLE_W}, 4'hF);
      wb_read(A_IDLE, d);
      n_cmp++; if (d !== {12'h0, IDLE_W}) begin n_bad++; $display("FAIL idle_rw got=%h required=%h", d, {12'h0, IDLE_W}); end
      // partial byte select must not write
      wb_write(A_IDLE, 32'h0001_2345, 4'h3);
      wb_read(A_IDLE, d);
      n_cmp++; if (d !== {12'h0, IDLE_W}) begin n_bad++; $display("FAIL idle_sel got=%h required=%h", d, {12'h0, IDLE_W}); end
      // undecoded address: no ack, no side effect
      acks = 0;
      @(posedge clk); #1;
      wbs_if.wbs_cyc_i = 1'b1; wbs_if.wbs_stb_i = 1'b1; wbs_if.wbs_we_i = 1'b1;
      wbs_if.wbs_sel_i = 4'hF; wbs_if.wbs_adr_i = BASE + 32'h1C; wbs_if.wbs_dat_i = 32'h0000_0777;
      for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (wbs_if.wbs_ack_o === 1'b1) acks++; end
      wbs_if.wbs_cyc_i = 1'b0; wbs_if.wbs_stb_i = 1'b0; wbs_if.wbs_we_i = 1'b0;
      $display("wb write adr=%h dat=%h (undecoded) acks=%0d", BASE + 32'h1C, 32'h777, acks);
      n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL undecoded_ack got=%0d required=0", acks); end
      wb_read(A_IDLE, d);
      n_cmp++; if (d !== {12'h0, IDLE_W}) begin n_bad++; $display("FAIL undecoded_write got=%h required=%h", d, {12'h0, IDLE_W}); end
   endtask

   task automatic test_replay;
      logic [31:0] d;
      logic [19:0] exp_w [10];
      exp_w = '{IDLE_W, IDLE_W, 20'h5_AB40, 20'h1_1DDC, 20'h1_1DDC, 20'h1_1DDC,
                20'h1_1DDC, 20'h1_1DDC, IDLE_W, IDLE_W};
      wb_write(A_CTRL, 32'h2, 4'hF);
      @(negedge clk);
      n_cmp++; if (io_oeb !== 38'h30_0000_FFFF) begin n_bad++; $display("FAIL oe_on got=%h required=%h", io_oeb, 38'h30_0000_FFFF); end
      n_cmp++; if (io_out !== pad(IDLE_W)) begin n_bad++; $display("FAIL idle_word got=%h required=%h", io_out, pad(IDLE_W)); end
      wb_write(A_PUSH, 32'h0005_AB40, 4'hF);
      wb_write(A_PUSH, 32'h0041_1DDC, 4'hF);
      wb_read(A_STAT, d);
      n_cmp++; if (d !== 32'h002) begin n_bad++; $display("FAIL replay_level got=%h required=%h", d, 32'h002); end
      wb_write(A_CTRL, 32'h3, 4'hF);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_cmp++;
         if (io_out !== pad(exp_w[k])) begin n_bad++; $display("FAIL replay_cycle%0d got=%h required=%h", k, io_out, pad(exp_w[k])); end
      end
      wb_read(A_STAT, d);
      n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL replay_done_stat got=%h required=%h", d, 32'h100); end
   endtask

   task automatic test_overflow;
      logic [31:0] d;
      wb_write(A_CTRL, 32'h0, 4'hF);
      for (int i = 0; i < 17; i++) wb_write(A_PUSH, 32'(i), 4'hF);
      wb_read(A_STAT, d);
      n_cmp++; if (d !== 32'hA10) begin n_bad++; $display("FAIL ovf_stat got=%h required=%h", d, 32'hA10); end
      wb_write(A_STAT, 32'h800, 4'hF);
      wb_read(A_STAT, d);
      n_cmp++; if (d !== 32'h210) begin n_bad++; $display("FAIL ovf_clear got=%h required=%h", d, 32'h210); end
      wb_write(A_CTRL, 32'h6, 4'hF);
      wb_read(A_CTRL, d);
      n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL flush_selfclear got=%h required=%h", d, 32'h2); end
      wb_read(A_STAT, d);
      n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL flush_stat got=%h required=%h", d, 32'h100); end
   endtask

   task automatic test_back_to_back;
      logic exp_ack [4];
      exp_ack = '{1'b1, 1'b0, 1'b1, 1'b0};
      @(posedge clk); #1;
      wbs_if.wbs_cyc_i = 1'b1; wbs_if.wbs_stb_i = 1'b1; wbs_if.wbs_we_i = 1'b0;
      wbs_if.wbs_sel_i = 4'hF; wbs_if.wbs_adr_i = A_STAT;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         $display("wb held read adr=%h cycle=%0d ack=%b dat=%h", A_STAT, k, wbs_if.wbs_ack_o, wbs_if.wbs_dat_o);
         n_cmp++;
         if (wbs_if.wbs_ack_o !== exp_ack[k]) begin n_bad++; $display("FAIL b2b_ack%0d got=%b required=%b", k, wbs_if.wbs_ack_o, exp_ack[k]); end
      end
      wbs_if.wbs_cyc_i = 1'b0; wbs_if.wbs_stb_i = 1'b0;
   endtask

   task automatic test_abort;
      logic [31:0] d;
      wb_write(A_PUSH, 32'h0642_2ABC, 4'hF);
      wb_write(A_PUSH, 32'h0003_1234, 4'hF);
      wb_write(A_CTRL, 32'h3, 4'hF);
      repeat (3) @(negedge clk);
      n_cmp++; if (io_out !== pad(20'h2_2ABC)) begin n_bad++; $display("FAIL abort_hold got=%h required=%h", io_out, pad(20'h2_2ABC)); end
      wb_read(A_STAT, d);
      n_cmp++; if (d !== 32'h401) begin n_bad++; $display("FAIL abort_busy got=%h required=%h", d, 32'h401); end
      repeat (4) @(negedge clk);
      wb_write(A_CTRL, 32'h2, 4'hF);
      @(negedge clk);
      n_cmp++; if (io_out !== pad(20'h2_2ABC)) begin n_bad++; $display("FAIL abort_same_cycle got=%h required=%h", io_out, pad(20'h2_2ABC)); end
      @(negedge clk);
      n_cmp++; if (io_out !== pad(IDLE_W)) begin n_bad++; $display("FAIL abort_idle got=%h required=%h", io_out, pad(IDLE_W)); end
      wb_read(A_STAT, d);
      n_cmp++; if (d !== 32'h001) begin n_bad++; $display("FAIL abort_level got=%h required=%h", d, 32'h001); end
   endtask

   task automatic test_flush;
      logic [31:0] d;
      int          a5_cycles;
      a5_cycles = 0;
      d = '0;
      wb_write(A_CTRL, 32'h6, 4'hF);
      wb_write(A_PUSH, 32'h0140_00A5, 4'hF);
      for (int i = 1; i <= 3; i++) wb_write(A_PUSH, 32'(i), 4'hF);
      wb_write(A_CTRL, 32'h3, 4'hF);
      fork
         begin
            for (int k = 0; k < 30; k++) begin
               @(negedge clk);
               if (io_out === pad(20'h0_00A5)) a5_cycles++;
            end
         end
         begin
            repeat (6) @(negedge clk);
            wb_write(A_CTRL, 32'h7, 4'hF);
            wb_read(A_STAT, d);
         end
      join
      n_cmp++; if (d !== 32'h500) begin n_bad++; $display("FAIL flush_mid_stat got=%h required=%h", d, 32'h500); end
      n_cmp++; if (a5_cycles != 21) begin n_bad++; $display("FAIL flush_hold_len got=%0d required=21", a5_cycles); end
      n_cmp++; if (io_out !== pad(IDLE_W)) begin n_bad++; $display("FAIL flush_idle got=%h required=%h", io_out, pad(IDLE_W)); end
      wb_read(A_STAT, d);
      n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL flush_final_stat got=%h required=%h", d, 32'h100); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      wb_write(A_PUSH, 32'h0327_BEEF, 4'hF);
      wb_write(A_PUSH, 32'h0001_0001, 4'hF);
      wb_write(A_CTRL, 32'h3, 4'hF);
      repeat (5) @(negedge clk);
      n_cmp++; if (io_out !== pad(20'h7_BEEF)) begin n_bad++; $display("FAIL rst_pre_hold got=%h required=%h", io_out, pad(20'h7_BEEF)); end
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (io_out !== 38'h0) begin n_bad++; $display("FAIL rst_mid_io_out got=%h required=0", io_out); end
      n_cmp++; if (io_oeb !== 38'h3F_FFFF_FFFF) begin n_bad++; $display("FAIL rst_mid_oeb got=%h required=%h", io_oeb, 38'h3F_FFFF_FFFF); end
      n_cmp++; if (wbs_if.wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ack got=%b required=0", wbs_if.wbs_ack_o); end
      @(posedge clk); #1; rst = 1'b0;
      wb_read(A_STAT, d);
      n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL rst_mid_stat got=%h required=%h", d, 32'h100); end
      wb_read(A_CTRL, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mid_ctrl got=%h required=0", d); end
   endtask

   initial begin
      test_reset;
      test_registers;
      test_replay;
      test_overflow;
      test_back_to_back;
      test_abort;
      test_flush;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
